// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: parametrised register file with two registered read ports,
// one write port (same-cycle write-to-read bypass) and a per-register busy
// scoreboard for RAW hazard detection at decode.
// Optional build macro: REGFILE_ZERO_REG_EN (register 0 hardwired to zero).

// One read port: registered data/valid, bypass from the write port, busy lookup.
module regfile_2r1w_sb_rd #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2**ADDR_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  input  logic [NUM_REGS-1:0]              busy_vec,
  input  logic                             wr_eff,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             rd_en,
  input  logic [ADDR_W-1:0]                rd_addr,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             rd_valid,
  output logic                             busy
);
  logic              hit;
  logic [DATA_W-1:0] rd_next;

  assign hit  = wr_eff && (wr_addr == rd_addr);
  // A write landing this cycle resolves the hazard, matching the bypass.
  assign busy = busy_vec[rd_addr] & ~hit;

  // Read mux: bypass the in-flight write, else the stored value.
  always_comb begin
    rd_next = hit ? wr_data : regs[rd_addr];
`ifdef REGFILE_ZERO_REG_EN
    if (rd_addr == '0) rd_next = '0;
`endif
  end

  // Output register; data holds when no read is requested.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_next;
    end
  end
endmodule

module regfile_2r1w_sb #(
  parameter int                  DATA_W    = 32,
  parameter int                  ADDR_W    = 5,
  parameter logic [DATA_W-1:0]   RESET_VAL = '0,
  localparam int                 NUM_REGS  = 2**ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 rd_en_a,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  output logic [DATA_W-1:0]    rd_data_a,
  output logic                 rd_valid_a,
  input  logic                 rd_en_b,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [DATA_W-1:0]    rd_data_b,
  output logic                 rd_valid_b,
  input  logic                 iss_en,
  input  logic [ADDR_W-1:0]    iss_addr,
  output logic                 busy_a,
  output logic                 busy_b,
  output logic [NUM_REGS-1:0]  busy_vec
);
  localparam int NUM_RD = 2;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy_nxt;
  logic                            wr_eff;
  logic                            iss_eff;

  logic [NUM_RD-1:0]              rd_en_p;
  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr_p;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_data_p;
  logic [NUM_RD-1:0]              rd_valid_p;
  logic [NUM_RD-1:0]              busy_p;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_eff  = wr_en  & (wr_addr  != '0);
  assign iss_eff = iss_en & (iss_addr != '0);
`else
  assign wr_eff  = wr_en;
  assign iss_eff = iss_en;
`endif

  // Storage: reset loads RESET_VAL everywhere, then single write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (wr_eff) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard next state: writeback clears, issue sets; set applied last so it wins.
  always_comb begin
    busy_nxt = busy_vec;
    if (wr_eff)  busy_nxt[wr_addr]  = 1'b0;
    if (iss_eff) busy_nxt[iss_addr] = 1'b1;
  end

  // Scoreboard register; reset drops every outstanding producer.
  always_ff @(posedge clk) begin
    if (!reset) busy_vec <= '0;
    else        busy_vec <= busy_nxt;
  end

  assign rd_en_p   = {rd_en_b, rd_en_a};
  assign rd_addr_p = {rd_addr_b, rd_addr_a};

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_2r1w_sb_rd #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)
    ) u_rd (
      .clk     (clk),
      .reset   (reset),
      .regs    (regs),
      .busy_vec(busy_vec),
      .wr_eff  (wr_eff),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en_p[g]),
      .rd_addr (rd_addr_p[g]),
      .rd_data (rd_data_p[g]),
      .rd_valid(rd_valid_p[g]),
      .busy    (busy_p[g])
    );
  end

  assign rd_data_a  = rd_data_p[0];
  assign rd_data_b  = rd_data_p[1];
  assign rd_valid_a = rd_valid_p[0];
  assign rd_valid_b = rd_valid_p[1];
  assign busy_a     = busy_p[0];
  assign busy_b     = busy_p[1];
endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Scoreboard bench for regfile_2r1w_sb (default parameters: DATA_W=32, ADDR_W=5).
module tb_regfile_2r1w_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en_a, rd_en_b;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b;
  logic          iss_en;
  logic [AW-1:0] iss_addr;
  logic          busy_a, busy_b;
  logic [NR-1:0] busy_vec;

  always #5 clk = ~clk;

  regfile_2r1w_sb dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_a(busy_a), .busy_b(busy_b), .busy_vec(busy_vec)
  );

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
  } rd_exp_t;

  rd_exp_t       q_a[$], q_b[$];
  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_busy;
  logic [DW-1:0] m_da, m_db;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = '0; wr_data = '0;
    rd_en_a = 0; rd_addr_a = '0; rd_en_b = 0; rd_addr_b = '0;
    iss_en = 0; iss_addr = '0;
  endtask

  function automatic logic zero_reg(input logic [AW-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
    return a == '0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input logic w_eff);
    if (zero_reg(a)) return '0;
    if (w_eff && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  // One clock: check combinational busy, push expectations, update model, compare after edge.
  task automatic cycle();
    logic w_eff, i_eff;
    rd_exp_t ea, eb;
    #1;
    w_eff = wr_en && !zero_reg(wr_addr);
    i_eff = iss_en && !zero_reg(iss_addr);
    if (reset) begin
      chk("busy_a", busy_a, m_busy[rd_addr_a] & ~(w_eff && wr_addr == rd_addr_a));
      chk("busy_b", busy_b, m_busy[rd_addr_b] & ~(w_eff && wr_addr == rd_addr_b));
    end
    if (!reset) begin
      ea = '{1'b0, '0}; eb = '{1'b0, '0};
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_busy = '0;
    end else begin
      ea = rd_en_a ? '{1'b1, m_read(rd_addr_a, w_eff)} : '{1'b0, m_da};
      eb = rd_en_b ? '{1'b1, m_read(rd_addr_b, w_eff)} : '{1'b0, m_db};
      if (w_eff) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (i_eff) m_busy[iss_addr] = 1'b1;
    end
    m_da = ea.d; m_db = eb.d;
    q_a.push_back(ea); q_b.push_back(eb);
    @(posedge clk); #1;
    ea = q_a.pop_front(); eb = q_b.pop_front();
    chk("rd_valid_a", rd_valid_a, ea.v);
    chk("rd_data_a",  rd_data_a,  ea.d);
    chk("rd_valid_b", rd_valid_b, eb.v);
    chk("rd_data_b",  rd_data_b,  eb.d);
    chk("busy_vec",   busy_vec,   m_busy);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle(); wr_en = 1; wr_addr = a; wr_data = d; cycle();
  endtask

  task automatic rd2(input logic [AW-1:0] a, input logic [AW-1:0] b);
    idle(); rd_en_a = 1; rd_addr_a = a; rd_en_b = 1; rd_addr_b = b; cycle();
  endtask

  initial begin
    idle();
    m_busy = '0; m_da = '0; m_db = '0;
    @(posedge clk); #1;
    // Reset held two cycles while every strobe is active; nothing may take effect.
    reset = 0;
    wr_en = 1; wr_addr = 5'd4; wr_data = 32'hCAFE0004;
    iss_en = 1; iss_addr = 5'd4; rd_en_a = 1; rd_en_b = 1;
    cycle(); cycle();
    chk("rst_busy_vec", busy_vec, 32'h0);
    chk("rst_valid_a", rd_valid_a, 1'b0);
    reset = 1;
    for (int i = 0; i < NR; i++) rd2(i[AW-1:0], 5'(NR-1-i));
    chk("rst_r31_val", rd_data_a, 32'h0);

    // Write then read.
    wr(5'd7, 32'hDEADBEEF);
    rd2(5'd7, 5'd0);
    chk("wr_rd_r7", rd_data_a, 32'hDEADBEEF);
    chk("wr_rd_r7_v", rd_valid_a, 1'b1);

    // rd_en low: valid drops, data holds.
    idle(); cycle();
    chk("hold_r7", rd_data_a, 32'hDEADBEEF);

    // Bypass on both ports.
    wr(5'd3, 32'h11);
    idle(); wr_en = 1; wr_addr = 5'd3; wr_data = 32'h22;
    rd_en_a = 1; rd_addr_a = 5'd3; rd_en_b = 1; rd_addr_b = 5'd3; cycle();
    chk("byp_a", rd_data_a, 32'h22);
    chk("byp_b", rd_data_b, 32'h22);

    // Scoreboard set, combinational view, and writeback clear.
    idle(); iss_en = 1; iss_addr = 5'd5; cycle();
    idle(); rd_addr_a = 5'd5; #1;
    chk("busy_a_r5", busy_a, 1'b1);
    cycle();
    idle(); rd_addr_a = 5'd5; wr_en = 1; wr_addr = 5'd5; wr_data = 32'h5; #1;
    chk("busy_a_wr_r5", busy_a, 1'b0);
    cycle();
    chk("busy_vec5_clr", busy_vec[5], 1'b0);

    // Issue and writeback to the same register: set wins, data still updated.
    idle(); iss_en = 1; iss_addr = 5'd9; cycle();
    idle(); iss_en = 1; iss_addr = 5'd9; wr_en = 1; wr_addr = 5'd9; wr_data = 32'h99; cycle();
    chk("conf_busy9", busy_vec[9], 1'b1);
    rd2(5'd9, 5'd9);
    chk("conf_r9", rd_data_a, 32'h99);

    // Set and clear to different registers in one cycle.
    idle(); iss_en = 1; iss_addr = 5'd12; wr_en = 1; wr_addr = 5'd9; wr_data = 32'h77; cycle();
    chk("diff_busy", {busy_vec[12], busy_vec[9]}, 2'b10);

    // Register 0 behaviour depends on the build.
    idle(); iss_en = 1; iss_addr = 5'd0; wr_en = 1; wr_addr = 5'd0; wr_data = 32'h55; cycle();
    rd2(5'd0, 5'd0);
`ifdef REGFILE_ZERO_REG_EN
    chk("r0_rd", rd_data_a, 32'h0);
    chk("r0_busy", busy_vec[0], 1'b0);
`else
    chk("r0_rd", rd_data_a, 32'h55);
    chk("r0_busy", busy_vec[0], 1'b1);
`endif

    // Random traffic on a few registers to provoke collisions, with occasional reset.
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 59) != 0);
      wr_en     = $urandom_range(0, 1);
      wr_addr   = 5'($urandom_range(0, 7));
      wr_data   = $urandom;
      iss_en    = $urandom_range(0, 1);
      iss_addr  = 5'($urandom_range(0, 7));
      rd_en_a   = $urandom_range(0, 1);
      rd_addr_a = 5'($urandom_range(0, 7));
      rd_en_b   = $urandom_range(0, 1);
      rd_addr_b = 5'($urandom_range(0, 7));
      cycle();
    end
    reset = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
